ftrace_event_gen: RTL and testbench
===================================

# ftrace_event_gen

Producer side of the function-trace path. The block watches the retired-instruction stream at writeback and classifies each RISC-V `jal`/`jalr` as a call, a return, or (optionally) a tail call. It tracks a shadow call depth, queues the events in a small FIFO, and hands them over a valid/ready port to the simulation trace sink that forwards them to the DPI function tracer.

## Interface
Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, ≥2
- DEPTH_W, 8, width of the shadow call-depth counter

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high
- retire_valid  in  1  one instruction retires this cycle
- retire_pc  in  32  PC of the retiring instruction
- retire_nextpc  in  32  architectural next PC, i.e. the jump target
- retire_inst  in  32  raw instruction word
- ev_valid  out  1  event available at the FIFO head
- ev_ready  in  1  sink accepts the head event
- ev_pc  out  32  PC of the jump
- ev_target  out  32  target (nextpc)
- ev_inst  out  32  instruction word
- ev_kind  out  2  00 call, 01 return, 10 tail call
- ev_rd  out  5  rd field of the instruction
- ev_depth  out  DEPTH_W  call depth tagged on the event
- depth  out  DEPTH_W  current shadow depth
- drop_cnt  out  16  events lost to a full FIFO; saturating

## Operation
Classification is combinational on `retire_*` and is qualified by `retire_valid`. A link register is x1 or x5.
- `jal` (opcode 1101111) with rd = link register → call.
- `jalr` (opcode 1100111, funct3 000) with rd = link register → call.
- `jalr` with rd = x0 and rs1 = link register → return.
- Anything else, including `jal x0` → no event.

Depth and tagging:
- Call: `ev_depth` = depth before the call; depth += 1, saturating at all-ones.
- Return: depth −= 1, saturating at 0; `ev_depth` = depth after the decrement. Matched call/return pairs therefore carry equal tags.
- Depth updates on every classified event, whether or not the event is enqueued.

FIFO:
- An event is pushed on classification. A pop occurs when `ev_valid && ev_ready`.
- If the FIFO is full and no pop happens in the same cycle: the event is dropped and `drop_cnt` increments, saturating at 0xFFFF.
- If the FIFO is full and a pop happens in the same cycle: push and pop both occur, and nothing is dropped.
- Pop and push on an empty FIFO in the same cycle: the pop is impossible because `ev_valid` = 0, so only the push takes effect.
- Pointers wrap modulo FIFO_DEPTH. A count register of width log2(FIFO_DEPTH)+1 distinguishes full from empty.

Handshake:
- While `ev_valid && !ev_ready`, all `ev_*` outputs stay stable.
- `ev_valid` never drops without a pop.

## Timing
- Instruction retired in cycle N with the FIFO empty → `ev_valid` = 1 in N+1, with all payload registered.
- `depth` reflects the event from cycle N starting in N+1.
- Throughput is one event per cycle when `ev_ready` is held high.
- Reset values: `ev_valid` 0, `ev_*` payload 0, `depth` 0, `drop_cnt` 0, FIFO pointers and count 0.
- Reset asserted mid-operation flushes the FIFO in the next cycle. Any event retiring in the reset cycle is discarded.

## Configuration
- `FTRACE_TAILCALL_EN` defined:
  - `jalr` with rd = x0 and rs1 ≠ link register → tail-call event, `ev_kind` = 10.
  - Depth is unchanged; `ev_depth` = current depth.
- Not defined:
  - Such instructions produce no event.
  - `ev_kind` never takes the value 10.

## Structure
- Package `ftrace_pkg`:
  - opcode constants `OP_JAL` and `OP_JALR`
  - kind enum with values KIND_CALL, KIND_RET, KIND_TAIL
  - packed event struct: pc, target, inst, kind, rd, depth
  - helper function `is_link(reg5)`
- Sub-module `ftrace_fifo`:
  - parameterised synchronous FIFO storing the packed struct
  - push/pop/full/empty ports
  - head output registered
- The top level holds the classifier, the depth counter and the drop counter.

## Test plan
- Retire `jal ra` (inst 0x0100_00EF, pc 0x8000_0000, nextpc 0x8000_0010), `ev_ready` = 1 → next cycle `ev_valid` = 1, kind 00, `ev_depth` 0; `depth` becomes 1.
- Call followed by `ret` (0x0000_8067) → two events: kind 00 with `ev_depth` 0, then kind 01 with `ev_depth` 0; `depth` returns to 0.
- `ret` at depth 0 → event kind 01, `ev_depth` 0, `depth` stays 0 (saturation).
- `ev_ready` = 0, then 6 consecutive calls with FIFO_DEPTH = 4 → 4 events queued with `ev_depth` 0–3, `drop_cnt` = 2, `depth` = 6. Raising `ev_ready` drains them in order, with payload stable while stalled.
- FIFO full plus a simultaneous pop and a new call → no drop, count stays 4. `jalr x0, 0(a5)` → no event without `FTRACE_TAILCALL_EN`, kind 10 with it.
- Reset asserted with 3 events queued → next cycle `ev_valid` = 0, `depth` = 0, `drop_cnt` = 0.

Source files
------------

// File: rtl/ftrace_pkg.sv
// Shared types for the function-trace producer: opcode constants, event kinds,
// the packed event record carried through the queue, and the link-register test.
package ftrace_pkg;

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   // Depth field width inside the stored record; the top tags events with its
   // own DEPTH_W (which must not exceed this) and zero-extends into the record.
   localparam int DEPTH_W_MAX = 16;

   typedef enum logic [1:0] {
      KIND_CALL = 2'b00,
      KIND_RET  = 2'b01,
      KIND_TAIL = 2'b10
   } kind_e;

   typedef struct packed {
      logic [31:0]            pc;
      logic [31:0]            target;
      logic [31:0]            inst;
      kind_e                  kind;
      logic [4:0]             rd;
      logic [DEPTH_W_MAX-1:0] depth;
   } event_t;

   // x1 (ra) and x5 (t0) are the RISC-V link registers.
   function automatic logic is_link(input logic [4:0] reg5);
      return (reg5 == 5'd1) || (reg5 == 5'd5);
   endfunction

endpackage

// File: rtl/ftrace_fifo.sv
// Synchronous event queue; the head is read straight out of the storage flops,
// so the payload seen downstream is always registered.
module ftrace_fifo
   import ftrace_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   push,
   input  event_t push_data,
   input  logic   pop,
   output event_t head,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   event_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/ftrace_event_gen.sv
// Classifies retiring jal/jalr as call/return (and tail call when built with
// FTRACE_TAILCALL_EN), tracks shadow call depth and queues events for the sink.
module ftrace_event_gen
   import ftrace_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DEPTH_W    = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               retire_valid,
   input  logic [31:0]        retire_pc,
   input  logic [31:0]        retire_nextpc,
   input  logic [31:0]        retire_inst,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [31:0]        ev_pc,
   output logic [31:0]        ev_target,
   output logic [31:0]        ev_inst,
   output logic [1:0]         ev_kind,
   output logic [4:0]         ev_rd,
   output logic [DEPTH_W-1:0] ev_depth,
   output logic [DEPTH_W-1:0] depth,
   output logic [15:0]        drop_cnt
);

   logic [6:0]         opcode;
   logic [4:0]         rd;
   logic [4:0]         rs1;
   logic [2:0]         funct3;
   logic               is_jal;
   logic               is_jalr;
   logic               is_call;
   logic               is_ret;
   logic               is_tail;
   logic               ev_hit;
   kind_e              kind;
   logic [DEPTH_W-1:0] depth_nxt;
   logic [DEPTH_W-1:0] tag;
   event_t             ev_new;
   event_t             head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               dropped;
   logic               unused_depth_hi;

   assign opcode = retire_inst[6:0];
   assign rd     = retire_inst[11:7];
   assign funct3 = retire_inst[14:12];
   assign rs1    = retire_inst[19:15];

   assign is_jal  = (opcode == OP_JAL);
   assign is_jalr = (opcode == OP_JALR) && (funct3 == 3'b000);

   assign is_call = retire_valid && (is_jal || is_jalr) && is_link(rd);
   assign is_ret  = retire_valid && is_jalr && (rd == 5'd0) && is_link(rs1);
`ifdef FTRACE_TAILCALL_EN
   assign is_tail = retire_valid && is_jalr && (rd == 5'd0) && !is_link(rs1);
`else
   assign is_tail = 1'b0;
`endif
   assign ev_hit = is_call || is_ret || is_tail;

   // Calls are tagged with the pre-call depth and returns with the post-return
   // depth, so a matched pair carries the same tag.
   always_comb begin
      kind      = KIND_CALL;
      depth_nxt = depth;
      tag       = depth;
      if (is_call) begin
         kind = KIND_CALL;
         if (depth != '1) begin
            depth_nxt = depth + 1'b1;
         end
      end else if (is_ret) begin
         kind = KIND_RET;
         if (depth != '0) begin
            depth_nxt = depth - 1'b1;
         end
         tag = depth_nxt;
      end else if (is_tail) begin
         kind = KIND_TAIL;
      end
   end

   always_comb begin
      ev_new        = '0;
      ev_new.pc     = retire_pc;
      ev_new.target = retire_nextpc;
      ev_new.inst   = retire_inst;
      ev_new.kind   = kind;
      ev_new.rd     = rd;
      ev_new.depth  = DEPTH_W_MAX'(tag);
   end

   assign pop     = ev_valid && ev_ready;
   assign dropped = ev_hit && fifo_full && !pop;

   // Depth follows every classified event, even one that is dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         depth    <= '0;
         drop_cnt <= '0;
      end else begin
         depth <= depth_nxt;
         if (dropped && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   ftrace_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (ev_hit),
      .push_data (ev_new),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign ev_valid  = !fifo_empty;
   assign ev_pc     = head.pc;
   assign ev_target = head.target;
   assign ev_inst   = head.inst;
   assign ev_kind   = head.kind;
   assign ev_rd     = head.rd;
   assign ev_depth  = head.depth[DEPTH_W-1:0];

   assign unused_depth_hi = ^head.depth;

endmodule

// File: tb/tb_ftrace_event_gen.sv
// Randomized scoreboard bench for ftrace_event_gen against a queue-level model
// of classification, depth tagging and bounded buffering.
module tb_ftrace_event_gen;

   localparam int FIFO_DEPTH = 4;
   localparam int DEPTH_W    = 8;
   localparam int EW         = 96 + 2 + 5 + DEPTH_W;
   localparam int DMAX       = (1 << DEPTH_W) - 1;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               retire_valid = 1'b0;
   logic [31:0]        retire_pc = '0;
   logic [31:0]        retire_nextpc = '0;
   logic [31:0]        retire_inst = '0;
   logic               ev_valid;
   logic               ev_ready = 1'b0;
   logic [31:0]        ev_pc;
   logic [31:0]        ev_target;
   logic [31:0]        ev_inst;
   logic [1:0]         ev_kind;
   logic [4:0]         ev_rd;
   logic [DEPTH_W-1:0] ev_depth;
   logic [DEPTH_W-1:0] depth;
   logic [15:0]        drop_cnt;

   ftrace_event_gen #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DEPTH_W    (DEPTH_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .retire_valid  (retire_valid),
      .retire_pc     (retire_pc),
      .retire_nextpc (retire_nextpc),
      .retire_inst   (retire_inst),
      .ev_valid      (ev_valid),
      .ev_ready      (ev_ready),
      .ev_pc         (ev_pc),
      .ev_target     (ev_target),
      .ev_inst       (ev_inst),
      .ev_kind       (ev_kind),
      .ev_rd         (ev_rd),
      .ev_depth      (ev_depth),
      .depth         (depth),
      .drop_cnt      (drop_cnt)
   );

   always #5 clock = ~clock;

   logic [EW-1:0] exp_q[$];
   int occ    = 0;
   int m_depth = 0;
   int m_drop = 0;
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Returns 0 call, 1 return, 2 tail call, -1 no event.
   function automatic int classify(input logic [31:0] inst);
      logic [6:0] opc;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [2:0] f3;
      bit         link_rd;
      opc = inst[6:0];
      rd  = inst[11:7];
      f3  = inst[14:12];
      rs1 = inst[19:15];
      link_rd = (rd == 5'd1) || (rd == 5'd5);
      if (opc == 7'h6f) return link_rd ? 0 : -1;
      if (opc != 7'h67 || f3 != 3'd0) return -1;
      if (link_rd) return 0;
      if (rd != 5'd0) return -1;
      if (rs1 == 5'd1 || rs1 == 5'd5) return 1;
`ifdef FTRACE_TAILCALL_EN
      return 2;
`else
      return -1;
`endif
   endfunction

   function automatic logic [31:0] enc_jal(input logic [4:0] rd);
      logic [19:0] imm;
      imm = 20'($urandom);
      return {imm, rd, 7'h6f};
   endfunction

   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [2:0] f3);
      logic [11:0] imm;
      imm = 12'($urandom);
      return {imm, rs1, f3, rd, 7'h67};
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [4:0] lnk;
      lnk = ($urandom_range(0, 1) == 1) ? 5'd1 : 5'd5;
      case ($urandom_range(0, 7))
         0:       return enc_jal(lnk);
         1:       return enc_jal(5'($urandom));
         2:       return enc_jalr(lnk, 5'($urandom), 3'd0);
         3:       return enc_jalr(5'd0, lnk, 3'd0);
         4:       return enc_jalr(5'd0, 5'($urandom), 3'd0);
         5:       return enc_jalr(5'($urandom), 5'($urandom), 3'($urandom));
         6:       return $urandom;
         default: return {12'($urandom), 5'($urandom), 3'd0, 5'($urandom), 7'h13};
      endcase
   endfunction

   // Drive one cycle of stimulus, advance the model, then check state after the edge.
   task automatic step(input logic rv, input logic [31:0] pc, input logic [31:0] npc,
                       input logic [31:0] inst, input logic rdy, input logic rst);
      int            k;
      int            tag;
      bit            pop;
      bit            push;
      logic [EW-1:0] ev;
      retire_valid  = rv;
      retire_pc     = pc;
      retire_nextpc = npc;
      retire_inst   = inst;
      ev_ready      = rdy;
      reset         = rst;
      k    = rv ? classify(inst) : -1;
      pop  = (occ > 0) && rdy;
      push = 0;
      ev   = '0;
      tag  = m_depth;
      if (k == 0) begin
         tag = m_depth;
         m_depth = (m_depth < DMAX) ? m_depth + 1 : DMAX;
      end else if (k == 1) begin
         m_depth = (m_depth > 0) ? m_depth - 1 : 0;
         tag = m_depth;
      end
      if (k >= 0) begin
         ev = {pc, npc, inst, 2'(k), inst[11:7], DEPTH_W'(tag)};
         if (occ < FIFO_DEPTH || pop) push = 1;
         else if (m_drop < 65535) m_drop++;
      end
      if (pop) occ--;
      if (push) occ++;
      @(posedge clock);
      #1;
      if (rst) begin
         exp_q.delete();
         occ = 0;
         m_depth = 0;
         m_drop = 0;
      end else if (push) begin
         exp_q.push_back(ev);
      end
      chk("depth", 128'(depth), 128'(m_depth));
      chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
      chk("ev_valid", 128'(ev_valid), 128'(occ > 0));
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
   endtask

   task automatic call(input logic rdy);
      step(1'b1, 32'h8000_0000 + ($urandom & 32'hFFFC), $urandom, enc_jal(5'd1), rdy, 1'b0);
   endtask

   // Head payload is compared whenever valid, so a stalled head must hold steady.
   always @(negedge clock) begin
      if (reset === 1'b0 && ev_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: pc %0h kind %0h with nothing expected", ev_pc, ev_kind);
         end else begin
            chk("event", 128'({ev_pc, ev_target, ev_inst, ev_kind, ev_rd, ev_depth}), 128'(exp_q[0]));
            if (ev_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("rst_ev_pc", 128'(ev_pc), 128'(0));
      chk("rst_ev_kind", 128'({ev_kind, ev_rd, ev_depth}), 128'(0));

      // Single call, then its return, then a return at depth 0.
      step(1'b1, 32'h8000_0000, 32'h8000_0010, 32'h0100_00EF, 1'b1, 1'b0);
      idle(1'b1);
      step(1'b1, 32'h8000_0014, 32'h8000_0004, 32'h0000_8067, 1'b1, 1'b0);
      idle(1'b1);
      step(1'b1, 32'h8000_0020, 32'h8000_0030, 32'h0000_8067, 1'b1, 1'b0);
      idle(1'b1);

      // Overflow: six calls into a stalled four-entry queue.
      for (int i = 0; i < 6; i++) call(1'b0);
      idle(1'b0);
      idle(1'b0);
      // Full queue with a simultaneous pop and a new call: nothing dropped.
      call(1'b1);
      for (int i = 0; i < 6; i++) idle(1'b1);

      // jalr x0, 0(a5): tail call or nothing depending on build.
      step(1'b1, 32'h8000_0100, 32'h8000_0200, 32'h0007_8067, 1'b1, 1'b0);
      idle(1'b1);

      // Reset with three events queued, and a call retiring in the reset cycle.
      for (int i = 0; i < 3; i++) call(1'b0);
      call(1'b1);
      step(1'b1, 32'h8000_0300, 32'h8000_0400, 32'h0100_00EF, 1'b0, 1'b1);
      idle(1'b1);

      // Depth saturation at all-ones, then step back down.
      for (int i = 0; i < DMAX + 4; i++) call(1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b1, $urandom, $urandom, enc_jalr(5'd0, 5'd5, 3'd0), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Randomized mix with random backpressure and occasional reset.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, rand_inst(),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
      end

      for (int i = 0; i < FIFO_DEPTH + 4; i++) idle(1'b1);
      chk("queue_drained", 128'(exp_q.size()), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
